// File: rtl/addend_vector_loader.sv
// addend_vector_loader: packs a sample stream into LENGTH-lane vectors for the adder tree; optional ADDEND_LOADER_STATS_EN adds vec_count
module addend_vector_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 16,
  parameter int TREE_DELAY = $clog2(LENGTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  output logic [DATA_WIDTH-1:0]        out_addends [LENGTH],
  output logic                         out_advance,
  output logic                         sum_valid,
  output logic [$clog2(LENGTH+1)-1:0]  sum_count,
  input  logic                         sum_ready
`ifdef ADDEND_LOADER_STATS_EN
  ,
  output logic [15:0]                  vec_count
`endif
);
  localparam int CW = $clog2(LENGTH+1);
  localparam int IW = LENGTH > 1 ? $clog2(LENGTH) : 1;
  logic [DATA_WIDTH-1:0] r_fill [LENGTH];
  logic [IW-1:0]         r_fill_idx;
  logic                  r_fill_done;
  logic [CW-1:0]         r_fill_cnt;
  logic [DATA_WIDTH-1:0] r_pres [LENGTH];
  logic                  r_pres_valid;
  logic [CW-1:0]         r_pres_cnt;
  logic                  w_tok_valid;
  logic [CW-1:0]         w_tok_cnt;
  logic                  w_accept;
  logic                  w_close;
  logic                  w_advance;
  assign w_accept    = in_valid && in_ready;
  assign w_close     = (r_fill_idx == IW'(LENGTH-1)) || in_last;
  assign w_advance   = reset && !(w_tok_valid && !sum_ready);
  assign out_advance = w_advance;
  assign in_ready    = reset && !r_fill_done;
  assign sum_valid   = reset && w_tok_valid;
  assign sum_count   = reset ? w_tok_cnt : '0;
  // addends are forced to zero while reset is held low
  always_comb
    for (int k = 0; k < LENGTH; k++) out_addends[k] = reset ? r_pres[k] : '0;
  // fill buffer: accept samples, close on last lane or in_last, clear lanes when handed off
  always_ff @(posedge clk)
    if (!reset) begin
      r_fill_idx  <= '0;
      r_fill_done <= 1'b0;
      r_fill_cnt  <= '0;
      for (int k = 0; k < LENGTH; k++) r_fill[k] <= '0;
    end else if (w_accept) begin
      r_fill[r_fill_idx] <= in_data;
      r_fill_cnt         <= CW'(r_fill_idx) + CW'(1);
      r_fill_done        <= w_close;
      r_fill_idx         <= w_close ? '0 : r_fill_idx + IW'(1);
    end else if (w_advance && r_fill_done) begin
      r_fill_done <= 1'b0;
      for (int k = 0; k < LENGTH; k++) r_fill[k] <= '0;
    end
  // presented buffer: takes a finished vector on advance, otherwise presents a zero bubble
  always_ff @(posedge clk)
    if (!reset) begin
      r_pres_valid <= 1'b0;
      r_pres_cnt   <= '0;
      for (int k = 0; k < LENGTH; k++) r_pres[k] <= '0;
    end else if (w_advance) begin
      r_pres_valid <= r_fill_done;
      r_pres_cnt   <= r_fill_done ? r_fill_cnt : '0;
      for (int k = 0; k < LENGTH; k++) r_pres[k] <= r_fill_done ? r_fill[k] : '0;
    end
  if (TREE_DELAY > 0) begin : g_tok
    logic [TREE_DELAY-1:0] r_tok_v;
    logic [CW-1:0]         r_tok_c [TREE_DELAY];
    // token pipeline mirrors the tree stages so sum_valid lines up with the tree output
    always_ff @(posedge clk)
      if (!reset) begin
        r_tok_v <= '0;
        for (int k = 0; k < TREE_DELAY; k++) r_tok_c[k] <= '0;
      end else if (w_advance) begin
        r_tok_v[0] <= r_pres_valid;
        r_tok_c[0] <= r_pres_cnt;
        for (int k = 1; k < TREE_DELAY; k++) begin
          r_tok_v[k] <= r_tok_v[k-1];
          r_tok_c[k] <= r_tok_c[k-1];
        end
      end
    assign w_tok_valid = r_tok_v[TREE_DELAY-1];
    assign w_tok_cnt   = r_tok_c[TREE_DELAY-1];
  end else begin : g_comb
    assign w_tok_valid = r_pres_valid;
    assign w_tok_cnt   = r_pres_cnt;
  end
`ifdef ADDEND_LOADER_STATS_EN
  // counts delivered sums, wrapping at 16 bits
  always_ff @(posedge clk)
    if (!reset) vec_count <= '0;
    else if (sum_valid && sum_ready) vec_count <= vec_count + 16'd1;
`endif
endmodule

// File: tb/tb_addend_vector_loader.sv
// tb_addend_vector_loader: scoreboard bench driving a TREE_DELAY=2 and a TREE_DELAY=0 loader with shared stimulus
module tb_addend_vector_loader;
  localparam int L = 4;
  typedef struct packed { logic [31:0] sum; logic [31:0] cnt; logic [31:0] lanes; } exp_t;
  logic clk = 0;
  logic reset = 0;
  logic [7:0] in_data = 0;
  logic in_valid = 0, in_last = 0;
  logic a_sr = 1, b_sr = 1;
  logic a_in_ready, b_in_ready, a_adv, b_adv, a_sv, b_sv;
  logic [2:0] a_sc, b_sc;
  logic [7:0] a_add [L];
  logic [7:0] b_add [L];
  logic [9:0] a_st [2];
  logic [9:0] a_in_sum, a_tree, b_tree;
`ifdef ADDEND_LOADER_STATS_EN
  logic [15:0] a_vc, b_vc;
`endif
  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_n = 0, hs_a = 0;
  bit rnd = 0, hold_a = 0;
  exp_t qa[$], qb[$];
  int cur[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  addend_vector_loader #(.DATA_WIDTH(8), .LENGTH(L), .TREE_DELAY(2)) u_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_last(in_last), .out_addends(a_add), .out_advance(a_adv), .sum_valid(a_sv),
    .sum_count(a_sc), .sum_ready(a_sr)
`ifdef ADDEND_LOADER_STATS_EN
    , .vec_count(a_vc)
`endif
  );
  addend_vector_loader #(.DATA_WIDTH(8), .LENGTH(L), .TREE_DELAY(0)) u_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_last(in_last), .out_addends(b_add), .out_advance(b_adv), .sum_valid(b_sv),
    .sum_count(b_sc), .sum_ready(b_sr)
`ifdef ADDEND_LOADER_STATS_EN
    , .vec_count(b_vc)
`endif
  );
  // attached trees: two-stage pipelined for A, combinational for B
  always_comb begin
    a_in_sum = '0;
    b_tree = '0;
    for (int k = 0; k < L; k++) begin
      a_in_sum += 10'(a_add[k]);
      b_tree += 10'(b_add[k]);
    end
  end
  always_ff @(posedge clk)
    if (a_adv) begin
      a_st[0] <= a_in_sum;
      a_st[1] <= a_st[0];
    end
  assign a_tree = a_st[1];
  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic model_accept(input int d, input bit l);
    exp_t e;
    cur.push_back(d);
    if (l || cur.size() == L) begin
      e = '0;
      e.cnt = cur.size();
      foreach (cur[i]) begin
        e.sum += cur[i];
        e.lanes[i*8 +: 8] = cur[i][7:0];
      end
      qa.push_back(e);
      qb.push_back(e);
      cur.delete();
    end
  endtask
  task automatic send(input logic [7:0] d, input bit l);
    int t = 0;
    while (!(a_in_ready && b_in_ready) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) chk("send_ready_timeout", t, 0);
    in_data = d;
    in_last = l;
    in_valid = 1;
    last_n = cyc;
    model_accept(d, l);
    @(posedge clk); #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic chk_reset_outs();
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    chk("rst_a_advance", a_adv, 0);
    chk("rst_b_advance", b_adv, 0);
    chk("rst_a_sum_valid", a_sv, 0);
    chk("rst_b_sum_valid", b_sv, 0);
    chk("rst_a_sum_count", a_sc, 0);
    chk("rst_b_sum_count", b_sc, 0);
    for (int i = 0; i < L; i++) begin
      chk($sformatf("rst_a_lane%0d", i), a_add[i], 0);
      chk($sformatf("rst_b_lane%0d", i), b_add[i], 0);
    end
  endtask
  task automatic do_reset(input int n);
    reset = 0;
    cur.delete();
    qa.delete();
    qb.delete();
    hs_a = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_reset_outs();
      @(posedge clk); #1;
    end
    reset = 1;
  endtask
  task automatic wait_drain(input string nm);
    int t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, "_a_pending"}, qa.size(), 0);
    chk({nm, "_b_pending"}, qb.size(), 0);
  endtask
  // random sum_ready generator
  initial forever begin
    @(posedge clk); #1;
    if (!hold_a) a_sr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    b_sr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  // monitor: pops the scoreboard on every sum handshake and checks stall behaviour
  initial begin
    bit ap = 0, bp = 0;
    logic [9:0] aps = 0, bps = 0;
    logic [2:0] apc = 0, bpc = 0;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!reset) begin
        ap = 0;
        bp = 0;
      end else begin
        if (ap) begin
          chk("a_hold_sum", a_tree, aps);
          chk("a_hold_cnt", a_sc, apc);
        end
        if (bp) begin
          chk("b_hold_sum", b_tree, bps);
          chk("b_hold_cnt", b_sc, bpc);
        end
        if (a_sv && !a_sr) chk("a_stall_advance", a_adv, 0);
        if (b_sv && !b_sr) chk("b_stall_advance", b_adv, 0);
`ifdef ADDEND_LOADER_STATS_EN
        chk("a_vec_count", a_vc, 16'(hs_a));
`endif
        if (a_sv && a_sr) begin
          chk("a_sum_expected", qa.size() > 0, 1);
          if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_sum", a_tree, e.sum);
            chk("a_count", a_sc, e.cnt);
          end
          hs_a++;
        end
        if (b_sv && b_sr) begin
          chk("b_sum_expected", qb.size() > 0, 1);
          if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_sum", b_tree, e.sum);
            chk("b_count", b_sc, e.cnt);
            for (int i = 0; i < L; i++) chk($sformatf("b_lane%0d", i), b_add[i], e.lanes[i*8 +: 8]);
          end
        end
        ap = a_sv && !a_sr;
        bp = b_sv && !b_sr;
        aps = a_tree;
        bps = b_tree;
        apc = a_sc;
        bpc = b_sc;
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int ta, tb, n;
    do_reset(2);
    // full vector, latency N+4 (tree delay 2) and N+2 (combinational)
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    ta = -1;
    tb = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_sv && ta < 0) ta = cyc;
      if (b_sv && tb < 0) tb = cyc;
    end
    chk("latency_a", ta - last_n, 4);
    chk("latency_b", tb - last_n, 2);
    wait_drain("s1");
    // early-terminated vector, then further fixed vectors
    send(5, 0); send(6, 1);
    send(2, 0); send(3, 0); send(4, 0); send(5, 0);
    repeat (4) send(255, 0);
    wait_drain("s2");
    // backpressure: hold sum_ready low for 10 cycles once the first sum appears
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    fork
      begin
        send(5, 0); send(6, 0); send(7, 0); send(8, 0);
      end
      begin
        int t = 0;
        while (!a_sv && t < 50) begin
          @(negedge clk);
          t++;
        end
        chk("s3_sum_valid_seen", a_sv, 1);
        hold_a = 1;
        a_sr = 0;
        for (int i = 0; i < 10; i++) begin
          #1;
          chk("s3_advance_low", a_adv, 0);
          chk("s3_sum_held", a_tree, 10);
          @(negedge clk);
        end
        chk("s3_in_ready_low", a_in_ready, 0);
        hold_a = 0;
        a_sr = 1;
      end
    join
    wait_drain("s3");
    // reset drops a partial vector
    send(9, 0); send(9, 0);
    do_reset(1);
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    wait_drain("s4");
    // randomized vectors, gaps and backpressure
    rnd = 1;
    for (int v = 0; v < 50; v++) begin
      n = $urandom_range(1, L);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send(8'($urandom), (i == n - 1) && (n < L || $urandom_range(0, 1) == 1));
      end
    end
    rnd = 0;
    wait_drain("rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/addend_vector_loader.md
Name: addend_vector_loader

Overview:
- Upstream feeder for the pipelined unsigned adder tree.
- Accepts a serial stream of unsigned samples over a valid/ready handshake and packs them into a LENGTH-lane vector. A vector may end early on in_last, in which case unused lanes are zero.
- Presents each vector on the tree's addend inputs and drives the tree's advance enable.
- Tracks which tree stages hold real vectors, so sum_valid / sum_count line up exactly with the tree's sum output. Honours downstream backpressure by stalling the tree.

Parameters:
DATA_WIDTH, 8, width of each sample/lane
LENGTH, 16, lanes per vector; must match the tree's LENGTH
TREE_DELAY, $clog2(LENGTH), register stages in the attached tree (0 = combinational tree)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
in_data  input  DATA_WIDTH  sample
in_valid  input  1  sample present
in_ready  output  1  loader can accept a sample
in_last  input  1  this sample closes the current vector
out_addends  output  DATA_WIDTH x LENGTH (unpacked array)  to tree addend inputs
out_advance  output  1  to tree advance enable
sum_valid  output  1  tree sum output currently holds a real vector's sum
sum_count  output  $clog2(LENGTH+1)  number of real samples in that vector
sum_ready  input  1  consumer takes the sum this cycle

Behaviour:
- Registers:
  - fill buffer: LENGTH lanes, fill_idx, fill_done, fill_cnt
  - presented buffer: drives out_addends, plus pres_valid and pres_cnt
  - token pipeline: TREE_DELAY entries of {valid, count}
- Reset (reset==0 at a clock edge) clears every register; partial or in-flight vectors are dropped.
  - Values visible while in reset: in_ready=0, out_advance=0, out_addends all zero, sum_valid=0, sum_count=0.
- in_ready = !fill_done (while out of reset).
- Sample accept, on in_valid && in_ready:
  - lane[fill_idx] <= in_data; fill_cnt <= fill_idx+1.
  - If fill_idx==LENGTH-1 or in_last: fill_done<=1 and fill_idx<=0. Otherwise fill_idx++.
  - in_last on lane LENGTH-1 behaves as a normal full vector.
- Stall and advance:
  - stall = sum_valid && !sum_ready.
  - out_advance = !stall (while out of reset). When idle, the tree keeps advancing and flushes zero bubbles.
- On out_advance=1:
  - The token pipeline shifts: the newest entry loads {pres_valid, pres_cnt}; the oldest entry is discarded.
  - If fill_done: the presented buffer loads the fill buffer, pres_valid<=1, pres_cnt<=fill_cnt; the fill buffer lanes are cleared to zero and fill_done<=0.
  - Else: the presented buffer is zeroed, pres_valid<=0, pres_cnt<=0 (bubble).
- On out_advance=0: the presented buffer and tokens hold. The fill buffer may keep filling until fill_done.
- Output alignment:
  - TREE_DELAY>0: sum_valid/sum_count come from the oldest token.
  - TREE_DELAY==0: sum_valid = pres_valid and sum_count = pres_cnt.
- Latency: with no stall, the last sample accepted in cycle N gives sum_valid in cycle N+2+TREE_DELAY.
- Throughput: one vector per max(LENGTH,2) cycles with continuous input (one-cycle fill_done bubble allowed).
- Unwritten lanes are always zero because lanes are cleared on transfer, so early-terminated vectors sum correctly.
- Simultaneous events:
  - Accepting the last sample and advancing in the same cycle is legal; the transfer happens on the following advance.
  - A stall asserted while fill_done=1 holds in_ready=0 until the stall releases.
- Sums are delivered in order; none are dropped or duplicated under any sum_ready pattern.

Optional Feature:
- Macro: ADDEND_LOADER_STATS_EN.
- When defined, adds output vec_count (16 bits). It increments on each cycle with sum_valid && sum_ready, wraps 0xFFFF->0, and resets to 0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Setup for all scenarios unless stated: DATA_WIDTH=8, LENGTH=4, TREE_DELAY=2, real tree attached, sum_ready=1.
- Scenario 1: stream 1,2,3,4 back-to-back, last accepted in cycle N -> sum_valid only in cycle N+4; tree sum=10; sum_count=4.
- Scenario 2: send 5,6 with in_last on 6 -> tree sum=11, sum_count=2; out_addends lanes 2,3 equal 0 while presented.
- Scenario 3: send vectors 1,2,3,4 and 5,6,7,8 with sum_ready=0 for 10 cycles once sum_valid rises ->
  - out_advance=0 and the sum is held at 10.
  - in_ready drops after the second vector fills.
  - On release, the sums are 10 then 26, each valid for exactly one accepted cycle.
- Scenario 4: accept 9,9, then pull reset low for 1 cycle, then send 1,1,1,1 -> during reset all outputs are 0; the next sum is 4 with count 4; no stale 18 ever appears.
- Scenario 5: send 255 x4 -> sum 1020 without truncation; with ADDEND_LOADER_STATS_EN, vec_count=1 after the handshake.
- Scenario 6: TREE_DELAY=0 with a combinational tree, send 2,3,4,5 -> sum 14 in cycle N+2; sum_valid depends on sum_ready with no extra cycle.
